// File: rtl/lsu_wb_master.sv
// LSU-to-Wishbone B4 classic master: one single-beat load or store per access.
// Latency: cyc/stb the cycle after a request, lsu ack/err the cycle after termination (3 cycles minimum).
// Backpressure: lsu_stall_o holds the pipeline while a request is pending; slave waits extend BUS until ack/err/timeout.
module lsu_wb_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_dat_i,
  input  logic [3:0]  lsu_sel_i,
  input  logic        lsu_we_i,
  input  logic        lsu_re_i,
  output logic [31:0] lsu_dat_o,
  output logic        lsu_ack_o,
  output logic        lsu_err_o,
  output logic        lsu_stall_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter value on the last BUS cycle before the access is declared dead.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] rdat_q, rdat_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;

  // Next-state logic: latch the request in IDLE, wait for termination in BUS, report in RESP.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (lsu_we_i || lsu_re_i) begin
          state_d = BUS;
          cyc_d   = 1'b1;
          we_d    = lsu_we_i;   // a store wins when both are raised
          adr_d   = lsu_addr_i;
          sel_d   = lsu_sel_i;
          wdat_d  = lsu_dat_i;
          err_d   = 1'b0;
          cnt_d   = 16'd0;
        end
      end
      BUS: begin
        if (wb_err_i) begin
          // err takes priority over a simultaneous ack; no data capture
          state_d = RESP;
          cyc_d   = 1'b0;
          err_d   = 1'b1;
        end else if (wb_ack_i) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          err_d   = 1'b0;
          if (!we_q) begin
            rdat_d = wb_dat_i;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any bus cycle without generating a response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 32'd0;
      sel_q   <= 4'd0;
      wdat_q  <= 32'd0;
      rdat_q  <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_sel_o    = sel_q;
  assign wb_dat_o    = wdat_q;
  assign lsu_dat_o   = rdat_q;
  assign lsu_ack_o   = (state_q == RESP) && !err_q;
  assign lsu_err_o   = (state_q == RESP) && err_q;
  assign lsu_stall_o = (lsu_we_i | lsu_re_i) & (state_q != RESP);

endmodule

// File: tb/tb_lsu_wb_master.sv
// Self-checking bench for lsu_wb_master (instantiated with TIMEOUT=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected responses are queued when a request is driven and popped in RESP.
module tb_lsu_wb_master;

  localparam int TMO = 4;
  localparam logic [1:0] T_NONE = 2'd0, T_ACK = 2'd1, T_ERR = 2'd2, T_BOTH = 2'd3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] lsu_addr_i, lsu_dat_i, wb_dat_i;
  logic [3:0]  lsu_sel_i;
  logic        lsu_we_i, lsu_re_i, wb_ack_i, wb_err_i;
  logic [31:0] lsu_dat_o, wb_adr_o, wb_dat_o;
  logic        lsu_ack_o, lsu_err_o, lsu_stall_o, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;

  lsu_wb_master #(.TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lsu_addr_i(lsu_addr_i), .lsu_dat_i(lsu_dat_i), .lsu_sel_i(lsu_sel_i),
    .lsu_we_i(lsu_we_i), .lsu_re_i(lsu_re_i),
    .lsu_dat_o(lsu_dat_o), .lsu_ack_o(lsu_ack_o), .lsu_err_o(lsu_err_o),
    .lsu_stall_o(lsu_stall_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    int          wait_n;   // BUS cycles before the terminating one
    logic [1:0]  term;
    logic [31:0] rdat;
    logic        exp_we;
    logic        exp_err;
    int          exp_bus;  // number of BUS cycles
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] dat;
  } resp_t;

  vec_t        tbl[8];
  resp_t       sb_q[$];
  logic [31:0] model_rd;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Caller sits at a falling edge with the DUT in IDLE; returns at the falling edge of the IDLE cycle after RESP.
  task automatic run_vec(input vec_t v, input bit hold);
    resp_t e;
    int    nbus;
    lsu_we_i   = v.we;
    lsu_re_i   = v.re;
    lsu_addr_i = v.addr;
    lsu_sel_i  = v.sel;
    lsu_dat_i  = v.wdat;
    e.err = v.exp_err;
    if (!v.exp_err && !v.we && v.re) model_rd = v.rdat;
    e.dat = model_rd;
    sb_q.push_back(e);
    #1;
    check("idle_cyc", wb_cyc_o, 0);
    check("req_stall", lsu_stall_o, 1);
    nbus = 0;
    for (int k = 1; k <= TMO + 2; k++) begin
      @(negedge clk_i);
      if (!wb_cyc_o) break;
      nbus++;
      check("bus_stb", wb_stb_o, 1);
      check("bus_we", wb_we_o, v.exp_we);
      check("bus_adr", wb_adr_o, v.addr);
      check("bus_sel", wb_sel_o, v.sel);
      check("bus_dat", wb_dat_o, v.wdat);
      check("bus_stall", lsu_stall_o, 1);
      check("bus_no_resp", lsu_ack_o | lsu_err_o, 0);
      // disturb the LSU side; the bus side must not follow
      lsu_addr_i = $urandom & 32'hFFFF_FFFC;
      lsu_sel_i  = 4'($urandom);
      lsu_dat_i  = $urandom;
      if (k == v.wait_n + 1 && v.term != T_NONE) begin
        wb_ack_i = v.term[0];
        wb_err_i = v.term[1];
        wb_dat_i = v.rdat;
      end else begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = $urandom;
      end
    end
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = $urandom;
    check("bus_cycles", nbus, v.exp_bus);
    // RESP cycle
    check("resp_pulse", lsu_ack_o | lsu_err_o, 1);
    check("resp_cyc", wb_cyc_o, 0);
    check("resp_stall", lsu_stall_o, 0);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("resp_err", lsu_err_o, e.err);
      check("resp_ack", lsu_ack_o, !e.err);
      check("resp_rdat", lsu_dat_o, e.dat);
    end
    if (!hold) begin
      lsu_we_i = 1'b0;
      lsu_re_i = 1'b0;
    end
    @(negedge clk_i);
    check("post_cyc", wb_cyc_o, 0);
    check("post_pulse", lsu_ack_o | lsu_err_o, 0);
    check("post_rdat", lsu_dat_o, model_rd);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'h100, 4'b0011, 32'hBEEF_BEEF, 0, T_ACK,  32'h0,         1'b1, 1'b0, 1};
    tbl[1] = '{1'b0, 1'b1, 32'h200, 4'b1111, 32'h0,         3, T_ACK,  32'h1234_5678, 1'b0, 1'b0, 4};
    tbl[2] = '{1'b0, 1'b1, 32'h204, 4'b1111, 32'h0,         0, T_BOTH, 32'hAAAA_5555, 1'b0, 1'b1, 1};
    tbl[3] = '{1'b0, 1'b1, 32'h208, 4'b1100, 32'h0,         1, T_ERR,  32'h5555_5555, 1'b0, 1'b1, 2};
    tbl[4] = '{1'b0, 1'b1, 32'h20C, 4'b1111, 32'h0,         0, T_NONE, 32'h0,         1'b0, 1'b1, TMO};
    tbl[5] = '{1'b1, 1'b1, 32'h300, 4'b1111, 32'h1122_3344, 2, T_ACK,  32'h9999_9999, 1'b1, 1'b0, 3};
    tbl[6] = '{1'b0, 1'b1, 32'h30C, 4'b0001, 32'h0,         2, T_ACK,  32'hCAFE_F00D, 1'b0, 1'b0, 3};
    tbl[7] = '{1'b1, 1'b0, 32'h310, 4'b1000, 32'h5A5A_5A5A, 0, T_NONE, 32'h0,         1'b1, 1'b1, TMO};

    // reset with a request present: it must be ignored
    rst_i = 1'b1;
    lsu_we_i = 1'b1; lsu_re_i = 1'b0;
    lsu_addr_i = 32'h0000_0F00; lsu_sel_i = 4'hF; lsu_dat_i = 32'h1;
    wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    model_rd = 32'h0;
    repeat (3) @(negedge clk_i);
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_we", wb_we_o, 0);
    check("rst_adr", wb_adr_o, 0);
    check("rst_sel", wb_sel_o, 0);
    check("rst_wdat", wb_dat_o, 0);
    check("rst_rdat", lsu_dat_o, 0);
    check("rst_ack", lsu_ack_o, 0);
    check("rst_err", lsu_err_o, 0);
    lsu_we_i = 1'b0;
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < 8; i++) run_vec(tbl[i], 1'b0);

    // back-to-back: request held through RESP restarts from the following IDLE cycle
    run_vec('{1'b1, 1'b0, 32'h500, 4'b0110, 32'h0F0F_0F0F, 0, T_ACK, 32'h0, 1'b1, 1'b0, 1}, 1'b1);
    run_vec('{1'b0, 1'b1, 32'h504, 4'b1111, 32'h0, 1, T_ACK, 32'h7654_3210, 1'b0, 1'b0, 2}, 1'b0);

    // reset during the 2nd BUS cycle aborts; held request restarts after reset
    lsu_we_i = 1'b0; lsu_re_i = 1'b1;
    lsu_addr_i = 32'h400; lsu_sel_i = 4'hF; lsu_dat_i = 32'h0;
    @(negedge clk_i);
    check("abort_bus1", wb_cyc_o, 1);
    @(negedge clk_i);
    check("abort_bus2", wb_cyc_o, 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("abort_cyc", wb_cyc_o, 0);
    check("abort_stb", wb_stb_o, 0);
    check("abort_we", wb_we_o, 0);
    check("abort_adr", wb_adr_o, 0);
    check("abort_sel", wb_sel_o, 0);
    check("abort_rdat", lsu_dat_o, 0);
    check("abort_pulse", lsu_ack_o | lsu_err_o, 0);
    @(negedge clk_i);
    check("abort_hold_cyc", wb_cyc_o, 0);
    check("abort_hold_pulse", lsu_ack_o | lsu_err_o, 0);
    rst_i = 1'b0;
    model_rd = 32'h0;
    run_vec('{1'b0, 1'b1, 32'h400, 4'b1111, 32'h0, 0, T_ACK, 32'h0BAD_C0DE, 1'b0, 1'b0, 1}, 1'b0);

    check("sb_empty", sb_q.size(), 0);
    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
